// File: rtl/grid_io_pkg.sv
// Shared definitions for the perimeter I/O tile: per-pad config field layout
// and frame sizing.
package grid_io_pkg;

    localparam int CFG_BITS_PER_PAD = 3;
    localparam int OE_IDX           = 0;
    localparam int IE_IDX           = 1;
    localparam int INV_IDX          = 2;

    // Field order matches the bit positions in the shifted frame: {INV, IE, OE}
    typedef struct packed {
        logic inv;
        logic ie;
        logic oe;
    } pad_cfg_t;

    function automatic int total_bits(input int num_pads);
        return num_pads * CFG_BITS_PER_PAD;
    endfunction

endpackage

// File: rtl/grid_io_pad_cell.sv
// One GPIO pad: tristate driver with optional output inversion and gated
// input path. Purely combinational from the active config.
module grid_io_pad_cell
    import grid_io_pkg::*;
(
    input  pad_cfg_t i_cfg,
    input  logic     i_cfg_valid,
    input  logic     i_out,
    output logic     o_in,
    inout  wire      io_pad
);

    logic w_drive;
    logic w_data;

    // Until a config has been loaded the pad stays released and reads as 0
    assign w_drive = i_cfg_valid & i_cfg.oe;
    assign w_data  = i_out ^ i_cfg.inv;
    assign io_pad  = w_drive ? w_data : 1'bz;
    assign o_in    = i_cfg_valid & i_cfg.ie & io_pad;

endmodule

// File: rtl/grid_io_bank.sv
// Perimeter I/O tile: serial config chain into a shadow frame, explicit load
// into the active frame, and NUM_PADS pad cells driven from the active frame.
module grid_io_bank #(
    parameter int NUM_PADS         = 8,
    parameter int CFG_BITS_PER_PAD = 3
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                ccff_head,
    input  logic                ccff_en,
    input  logic                ccff_load,
    output logic                ccff_tail,
    output logic                cfg_full,
    output logic                cfg_valid,
    input  logic [NUM_PADS-1:0] io_outpad,
    output logic [NUM_PADS-1:0] io_inpad,
    inout  wire  [NUM_PADS-1:0] gfpga_pad_GPIO_PAD
);
    import grid_io_pkg::*;

    localparam int TOTAL = total_bits(NUM_PADS);
    localparam int CW    = $clog2(TOTAL + 1);

    if (CFG_BITS_PER_PAD != grid_io_pkg::CFG_BITS_PER_PAD ||
        NUM_PADS < 1 || NUM_PADS > 64) begin : g_bad_param
        $error("grid_io_bank: unsupported NUM_PADS or CFG_BITS_PER_PAD");
    end

    logic [TOTAL-1:0]         r_shadow;
    logic [TOTAL-1:0]         r_active;
    logic [CW-1:0]            r_bit_cnt;
    logic                     r_cfg_valid;
    pad_cfg_t [NUM_PADS-1:0]  w_cfg;

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_shadow <= '0;
        end else if (ccff_en) begin
            r_shadow <= {r_shadow[TOTAL-2:0], ccff_head};
        end
    end

    // Active frame samples the shadow before any same-cycle shift lands
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_active    <= '0;
            r_cfg_valid <= 1'b0;
        end else if (ccff_load) begin
            r_active    <= r_shadow;
            r_cfg_valid <= 1'b1;
        end
    end

    // A load restarts the frame count; a shift in the load cycle is its first bit
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_bit_cnt <= '0;
        end else if (ccff_load) begin
            r_bit_cnt <= ccff_en ? CW'(1) : '0;
        end else if (ccff_en && r_bit_cnt != CW'(TOTAL)) begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
        end
    end

    assign ccff_tail = r_shadow[TOTAL-1];
    assign cfg_full  = (r_bit_cnt == CW'(TOTAL));
    assign cfg_valid = r_cfg_valid;
    assign w_cfg     = r_active;

    for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
        grid_io_pad_cell u_cell (
            .i_cfg       (w_cfg[g]),
            .i_cfg_valid (r_cfg_valid),
            .i_out       (io_outpad[g]),
            .o_in        (io_inpad[g]),
            .io_pad      (gfpga_pad_GPIO_PAD[g])
        );
    end

endmodule

// File: tb/tb_grid_io_bank.sv
// Bench for grid_io_bank: frame-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_grid_io_bank;

    localparam int NP  = 8;
    localparam int TOT = 24;

    logic          prog_clk  = 1'b0;
    logic          pReset    = 1'b1;
    logic          ccff_head = 1'b0;
    logic          ccff_en   = 1'b0;
    logic          ccff_load = 1'b0;
    logic          ccff_tail;
    logic          cfg_full;
    logic          cfg_valid;
    logic [NP-1:0] io_outpad = 8'hFF;
    logic [NP-1:0] io_inpad;
    wire  [NP-1:0] pad;
    logic [NP-1:0] tb_oe  = '0;
    logic [NP-1:0] tb_val = '0;

    int checks = 0;
    int errors = 0;

    always #5 prog_clk = ~prog_clk;

    // Released pads read as 0; the bench can also act as an external driver
    for (genvar i = 0; i < NP; i++) begin : g_tbpad
        pulldown (pad[i]);
        assign pad[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    end

    grid_io_bank #(.NUM_PADS(NP), .CFG_BITS_PER_PAD(3)) dut (
        .prog_clk           (prog_clk),
        .pReset             (pReset),
        .ccff_head          (ccff_head),
        .ccff_en            (ccff_en),
        .ccff_load          (ccff_load),
        .ccff_tail          (ccff_tail),
        .cfg_full           (cfg_full),
        .cfg_valid          (cfg_valid),
        .io_outpad          (io_outpad),
        .io_inpad           (io_inpad),
        .gfpga_pad_GPIO_PAD (pad)
    );

    // Reference model: history of shifted bits, newest last
    bit mq[$];
    bit m_oe[NP];
    bit m_ie[NP];
    bit m_inv[NP];
    int m_cnt   = 0;
    bit m_valid = 1'b0;

    // Bit j of the shadow frame is the bit shifted j shifts ago
    function automatic bit sbit(input int j);
        if (j < mq.size()) return mq[mq.size() - 1 - j];
        return 1'b0;
    endfunction

    always @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            mq.delete();
            for (int p = 0; p < NP; p++) begin
                m_oe[p] = 0; m_ie[p] = 0; m_inv[p] = 0;
            end
            m_cnt   = 0;
            m_valid = 0;
        end else begin
            if (ccff_load) begin
                if (m_cnt != TOT)
                    $display("NOTE: use error, ccff_load with only %0d of %0d bits shifted at %0t", m_cnt, TOT, $time);
                for (int p = 0; p < NP; p++) begin
                    m_oe[p]  = sbit(3*p);
                    m_ie[p]  = sbit(3*p + 1);
                    m_inv[p] = sbit(3*p + 2);
                end
                m_valid = 1;
                m_cnt   = ccff_en ? 1 : 0;
            end else if (ccff_en && m_cnt < TOT) begin
                m_cnt++;
            end
            if (ccff_en) mq.push_back(ccff_head);
        end
    end

    function automatic logic [NP-1:0] exp_pad();
        logic [NP-1:0] e;
        for (int p = 0; p < NP; p++) begin
            if (m_valid && m_oe[p]) e[p] = io_outpad[p] ^ m_inv[p];
            else                    e[p] = tb_oe[p] ? tb_val[p] : 1'b0;
        end
        return e;
    endfunction

    function automatic logic [NP-1:0] exp_in();
        logic [NP-1:0] e;
        logic [NP-1:0] pe;
        pe = exp_pad();
        for (int p = 0; p < NP; p++) e[p] = m_valid & m_ie[p] & pe[p];
        return e;
    endfunction

    task automatic chk(input string name, input logic [NP-1:0] act, input logic [NP-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge prog_clk) begin
        chk("m_pad",       pad,                exp_pad());
        chk("m_io_inpad",  io_inpad,           exp_in());
        chk("m_ccff_tail", {7'b0, ccff_tail},  {7'b0, sbit(TOT-1)});
        chk("m_cfg_full",  {7'b0, cfg_full},   {7'b0, m_cnt == TOT});
        chk("m_cfg_valid", {7'b0, cfg_valid},  {7'b0, m_valid});
    end

    task automatic cyc(input logic en, input logic head, input logic load);
        ccff_en   = en;
        ccff_head = head;
        ccff_load = load;
        @(posedge prog_clk);
        #2;
        ccff_en   = 1'b0;
        ccff_load = 1'b0;
    endtask

    task automatic shift_frame(input logic [TOT-1:0] f);
        for (int i = TOT-1; i >= 0; i--) cyc(1'b1, f[i], 1'b0);
    endtask

    task automatic load();
        cyc(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [TOT-1:0] f;
        logic [29:0]    ob;
        logic [5:0]     first6;

        // Reset and idle: safe state with io_outpad all ones
        repeat (3) @(posedge prog_clk);
        #2 pReset = 1'b0;
        chk("rst_pad",       pad,               8'h00);
        chk("rst_io_inpad",  io_inpad,          8'h00);
        chk("rst_tail",      {7'b0, ccff_tail}, 8'h00);
        chk("rst_full",      {7'b0, cfg_full},  8'h00);
        chk("rst_valid",     {7'b0, cfg_valid}, 8'h00);

        // All pads OE=1 IE=1
        io_outpad = 8'hA5;
        shift_frame({8{3'b011}});
        chk("full_after24",  {7'b0, cfg_full},  8'h01);
        load();
        chk("drv_pad",       pad,               8'hA5);
        chk("drv_io_inpad",  io_inpad,          8'hA5);
        chk("full_after_ld", {7'b0, cfg_full},  8'h00);
        chk("valid_after_ld",{7'b0, cfg_valid}, 8'h01);

        // Input-only pads, externally driven, then gate pad 2 input
        shift_frame({8{3'b010}});
        load();
        tb_val = 8'h3C;
        tb_oe  = 8'hFF;
        #1;
        chk("in_io_inpad",   io_inpad,          8'h3C);
        f = {8{3'b010}};
        f[7] = 1'b0;
        shift_frame(f);
        load();
        chk("ie2_io_inpad",  io_inpad,          8'h38);
        tb_oe = 8'h00;

        // Shadow shifting must not disturb the active frame
        io_outpad = 8'h0F;
        shift_frame({8{3'b001}});
        load();
        chk("oe_pad",        pad,               8'h0F);
        chk("oe_io_inpad",   io_inpad,          8'h00);
        f = {8{3'b111}};
        for (int i = TOT-1; i >= 0; i--) begin
            cyc(1'b1, f[i], 1'b0);
            chk("hold_pad",  pad,               8'h0F);
        end
        load();
        chk("inv_pad",       pad,               8'hF0);
        chk("inv_io_inpad",  io_inpad,          8'hF0);

        // Over-shift: bits 0..5 of ob appear on the tail during shifts 25..30
        ob     = 30'h0F0F0F0D;
        first6 = 6'b001101;
        for (int k = 0; k < 30; k++) begin
            if (k >= TOT) chk("ovr_tail", {7'b0, ccff_tail}, {7'b0, first6[k-TOT]});
            cyc(1'b1, ob[k], 1'b0);
            if (k == TOT-2) chk("full_at23", {7'b0, cfg_full}, 8'h00);
            if (k >= TOT-1) chk("ovr_full",  {7'b0, cfg_full}, 8'h01);
        end
        load();

        // Partial frame load: pad 0 becomes OE, IE, INV
        io_outpad = 8'hF0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
        chk("part_full",     {7'b0, cfg_full},  8'h00);
        load();
        chk("part_pad0",     {7'b0, pad[0]},      8'h01);
        chk("part_in0",      {7'b0, io_inpad[0]}, 8'h01);

        // Load with a simultaneous shift counts that shift as bit 1
        f = {8{3'b011}};
        cyc(1'b1, f[TOT-1], 1'b1);
        chk("ldsh_full",     {7'b0, cfg_full},  8'h00);
        for (int i = TOT-2; i >= 1; i--) cyc(1'b1, f[i], 1'b0);
        chk("ldsh_full23",   {7'b0, cfg_full},  8'h00);
        cyc(1'b1, f[0], 1'b0);
        chk("ldsh_full24",   {7'b0, cfg_full},  8'h01);
        io_outpad = 8'hC3;
        load();
        chk("ldsh_pad",      pad,               8'hC3);
        chk("ldsh_io_inpad", io_inpad,          8'hC3);

        // Asynchronous reset in the middle of a frame
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0);
        #1 pReset = 1'b1;
        #1;
        chk("arst_pad",      pad,               8'h00);
        chk("arst_io_inpad", io_inpad,          8'h00);
        chk("arst_valid",    {7'b0, cfg_valid}, 8'h00);
        chk("arst_tail",     {7'b0, ccff_tail}, 8'h00);
        chk("arst_full",     {7'b0, cfg_full},  8'h00);
        @(posedge prog_clk);
        #2 pReset = 1'b0;

        // Fresh frame after the abort: pad 7 input-only, others drive
        f = {3'b010, {7{3'b011}}};
        for (int i = TOT-1; i >= 0; i--) begin
            cyc(1'b1, f[i], 1'b0);
            if (i == 10) chk("rf_full14", {7'b0, cfg_full}, 8'h00);
        end
        chk("rf_full24",     {7'b0, cfg_full},  8'h01);
        load();
        chk("rf_pad",        pad,               8'h43);
        chk("rf_io_inpad",   io_inpad,          8'h43);
        chk("rf_valid",      {7'b0, cfg_valid}, 8'h01);

        repeat (2) cyc(1'b0, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
